debounce_multi: RTL and testbench

//   Multi-channel parametrised button conditioner; successor to the single-input debouncer.
//   Per channel: synchroniser, stable-count filter, clean level, one-cycle press/release pulses.

---
 rtl/debounce_multi_if.sv | 21 ++
 rtl/debounce_multi.sv | 120 ++++++++++++
 tb/tb_debounce_multi.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/debounce_multi_if.sv
// Button-conditioner bus: raw inputs in, debounced level and edge pulses out.
// The design side uses the slave modport; the stimulus/board side uses master.
interface debounce_multi_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0] noisy_in;
  logic [CHANNELS-1:0] clean_level;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic                any_press;

  modport master (
    output noisy_in,
    input  clean_level, press_pulse, release_pulse, any_press
  );

  modport slave (
    input  noisy_in,
    output clean_level, press_pulse, release_pulse, any_press
  );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel button conditioner: synchroniser, stable-count filter, press/release pulses.
// Define DEBOUNCE_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module debounce_multi #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input logic             clk,
  input logic             rst,
  debounce_multi_if.slave bus
);
  localparam int unsigned CW = $clog2(STABLE_CYCLES) + 1;

  // Elaboration-time parameter range checks
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("debounce_multi: CHANNELS must be 1..32");
  end
  if (SYNC_STAGES < 2 || STABLE_CYCLES < 2) begin : g_bad_filter
    $error("debounce_multi: SYNC_STAGES and STABLE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
    $error("debounce_multi: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_last;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [CHANNELS-1:0] clean_q, clean_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic                any_q;

  assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW   = $clog2(RMAX) + 1;

  logic [HW-1:0]       hold_q [CHANNELS];
  logic [HW-1:0]       hold_d [CHANNELS];
  logic [CHANNELS-1:0] first_q, first_d;
`endif

  // Next-state: filter acceptance, edge pulses and optional repeat timing
  always_comb begin
    clean_d   = clean_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_d[i] = '0;
      if (sync_last[i] != clean_q[i]) begin
        if (cnt_q[i] == CW'(STABLE_CYCLES - 1)) begin
          clean_d[i]   = sync_last[i];
          press_d[i]   = sync_last[i];
          release_d[i] = ~sync_last[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
`ifdef DEBOUNCE_AUTOREPEAT_EN
    // Hold timer runs only while the level is 1 and stays 1 this cycle
    for (int i = 0; i < int'(CHANNELS); i++) begin
      hold_d[i]  = '0;
      first_d[i] = 1'b1;
      if (clean_q[i] && clean_d[i]) begin
        first_d[i] = first_q[i];
        if (hold_q[i] == (first_q[i] ? HW'(REPEAT_DELAY - 1) : HW'(REPEAT_PERIOD - 1))) begin
          press_d[i] = 1'b1;
          hold_d[i]  = '0;
          first_d[i] = 1'b0;
        end else begin
          hold_d[i] = hold_q[i] + HW'(1);
        end
      end
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) cnt_q[i] <= '0;
      clean_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
    end else begin
      sync_q[0] <= bus.noisy_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < int'(CHANNELS); i++) cnt_q[i] <= cnt_d[i];
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= |press_d;
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(CHANNELS); i++) hold_q[i] <= '0;
      first_q <= '1;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) hold_q[i] <= hold_d[i];
      first_q <= first_d;
    end
  end
`endif

  assign bus.clean_level   = clean_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.any_press     = any_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: run-length reference model, directed then random stimulus.
module tb_debounce_multi;
  localparam int CH      = 4;
  localparam int SYNC    = 2;
  localparam int STABLE  = 4;
  localparam int RDELAY  = 16;
  localparam int RPERIOD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #25 clk = ~clk;

  debounce_multi_if #(.CHANNELS(CH)) bus ();

  debounce_multi #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
    .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [CH-1:0] clean;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic          any;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   started     = 1'b0;
  int   cyc         = 0;

  // Reference model state: input history since reset, per-channel run lengths
  logic [CH-1:0] m_hist[$];
  int            m_n;
  logic [CH-1:0] m_clean;
  logic [CH-1:0] m_prev;
  int            m_run[CH];
  int            m_press_at[CH];

  // Predict the outputs visible after the next rising edge
  task automatic model_step(input logic [CH-1:0] din, input logic r);
    exp_t          e;
    logic [CH-1:0] smp;
    int            k;
    e = '0;
    if (r) begin
      m_hist.delete();
      m_n     = 0;
      m_clean = '0;
      m_prev  = '0;
      for (int i = 0; i < CH; i++) begin
        m_run[i]      = 0;
        m_press_at[i] = 0;
      end
      sb.push_back(e);
      return;
    end
    m_hist.push_back(din);
    m_n++;
    // The filter sees the input that was sampled SYNC edges earlier (zeros before that)
    smp = (m_hist.size() > SYNC) ? m_hist[m_hist.size() - 1 - SYNC] : '0;
    for (int i = 0; i < CH; i++) begin
      m_run[i] = (smp[i] == m_prev[i]) ? m_run[i] + 1 : 1;
      if (smp[i] != m_clean[i] && m_run[i] >= STABLE) begin
        m_clean[i] = smp[i];
        e.press[i] = smp[i];
        e.rel[i]   = ~smp[i];
        if (smp[i]) m_press_at[i] = m_n;
      end
`ifdef DEBOUNCE_AUTOREPEAT_EN
      else if (m_clean[i]) begin
        k = m_n - m_press_at[i];
        if (k >= RDELAY && ((k - RDELAY) % RPERIOD) == 0) e.press[i] = 1'b1;
      end
`endif
    end
    k      = 0;
    m_prev = smp;
    e.clean = m_clean;
    e.any   = |e.press;
    sb.push_back(e);
  endtask

  task automatic cycle(input logic [CH-1:0] din, input logic r);
    @(negedge clk);
    rst          = r;
    bus.noisy_in = din;
    model_step(din, r);
    started = 1'b1;
  endtask

  // Monitor: one expected entry per rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() == 0) begin
        if (started) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard_empty cycle %0d", cyc);
        end
      end else begin
        e = sb.pop_front();
        vectors++;
        if (bus.clean_level !== e.clean || bus.press_pulse !== e.press ||
            bus.release_pulse !== e.rel || bus.any_press !== e.any) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got clean=%h press=%h rel=%h any=%b, want clean=%h press=%h rel=%h any=%b",
                   cyc, bus.clean_level, bus.press_pulse, bus.release_pulse, bus.any_press,
                   e.clean, e.press, e.rel, e.any);
        end
      end
    end
  end

  initial begin
    logic [CH-1:0] din;
    bus.noisy_in = '0;

    // Reset with all buttons held, then release and let them debounce
    repeat (2) cycle(4'hF, 1'b1);
    repeat (12) cycle(4'hF, 1'b0);

    // Asynchronous reset: outputs clear without waiting for a clock edge
    @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.clean_level !== '0 || bus.press_pulse !== '0 ||
        bus.release_pulse !== '0 || bus.any_press !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got clean=%h press=%h rel=%h any=%b, want all 0",
               bus.clean_level, bus.press_pulse, bus.release_pulse, bus.any_press);
    end
    repeat (2) cycle(4'hF, 1'b1);
    repeat (10) cycle(4'h0, 1'b0);

    // Bounce on ch1 press, then symmetric bounce on release
    cycle(4'h2, 1'b0); cycle(4'h0, 1'b0); cycle(4'h2, 1'b0); cycle(4'h0, 1'b0);
    repeat (10) cycle(4'h2, 1'b0);
    cycle(4'h0, 1'b0); cycle(4'h2, 1'b0); cycle(4'h0, 1'b0); cycle(4'h2, 1'b0);
    repeat (10) cycle(4'h0, 1'b0);

    // Short glitch on ch0 must be ignored
    repeat (3) cycle(4'h1, 1'b0);
    repeat (10) cycle(4'h0, 1'b0);

    // Simultaneous ch2 press and ch3 release
    repeat (10) cycle(4'h8, 1'b0);
    repeat (10) cycle(4'h4, 1'b0);
    repeat (10) cycle(4'h0, 1'b0);

    // Reset in the middle of a count, input still held afterwards
    repeat (5) cycle(4'h1, 1'b0);
    repeat (2) cycle(4'h1, 1'b1);
    repeat (10) cycle(4'h1, 1'b0);

    // Long hold for auto-repeat, then release
    repeat (10) cycle(4'h0, 1'b0);
    repeat (50) cycle(4'h1, 1'b0);
    repeat (15) cycle(4'h0, 1'b0);

    // Random: noisy toggling with occasional long steady holds and resets
    din = '0;
    for (int n = 0; n < 3000; n++) begin
      if ((n % 200) < 40) begin
        cycle(din, 1'b0);
      end else if ($urandom_range(0, 399) == 0) begin
        repeat ($urandom_range(1, 2)) cycle(din, 1'b1);
      end else begin
        for (int i = 0; i < CH; i++)
          if ($urandom_range(0, 7) == 0) din[i] = ~din[i];
        cycle(din, 1'b0);
      end
    end

    // Drain the final expectation
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
